// File: rtl/mem_arbiter.sv
// Arbitrates the single-ported main memory between the I-cache fill FSM and the D-cache.
// Stores win outright; competing fills alternate; a fill owns memory until its last beat.
module mem_arbiter #(
  parameter int BEATS = 8,
  parameter int CNT_W = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  input  logic        mem_data_valid,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        i_grant,
  output logic        d_grant,
  output logic        i_data_valid,
  output logic        d_data_valid,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    I_FILL  = 2'd1,
    D_FILL  = 2'd2,
    D_WRITE = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_i_q, last_i_d;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      last_i_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_i_q <= last_i_d;
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    last_i_d = last_i_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (d_req && d_wr) begin
          state_d = D_WRITE;
        end else if (i_req && d_req) begin
          // Both want a fill: whoever did not fill last time goes now.
          if (last_i_q) begin
            state_d  = D_FILL;
            last_i_d = 1'b0;
          end else begin
            state_d  = I_FILL;
            last_i_d = 1'b1;
          end
        end else if (d_req) begin
          state_d  = D_FILL;
          last_i_d = 1'b0;
        end else if (i_req) begin
          state_d  = I_FILL;
          last_i_d = 1'b1;
        end
      end
      I_FILL, D_FILL: begin
        // Requests are ignored here; only the beat count ends a fill.
        if (mem_data_valid) begin
          if (cnt_q == LAST_BEAT) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      D_WRITE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_en       = 1'b0;
    mem_wr       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    i_grant      = 1'b0;
    d_grant      = 1'b0;
    i_data_valid = 1'b0;
    d_data_valid = 1'b0;
    busy         = (state_q != IDLE);
    case (state_q)
      I_FILL: begin
        i_grant      = 1'b1;
        mem_en       = i_req;
        mem_addr     = i_addr;
        i_data_valid = mem_data_valid;
      end
      D_FILL: begin
        d_grant      = 1'b1;
        mem_en       = d_req;
        mem_addr     = d_addr;
        d_data_valid = mem_data_valid;
      end
      D_WRITE: begin
        d_grant   = 1'b1;
        mem_en    = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = d_addr;
        mem_wdata = d_wdata;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus queues expected memory-side events,
// a negedge monitor pops and compares each steered beat or store it observes.
module tb_mem_arbiter;

  localparam int BEATS = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req, d_req, d_wr, mem_data_valid;
  logic [15:0] i_addr, d_addr, d_wdata;
  logic        mem_en, mem_wr, i_grant, d_grant, i_data_valid, d_data_valid, busy;
  logic [15:0] mem_addr, mem_wdata;

  mem_arbiter #(.BEATS(BEATS), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .mem_data_valid(mem_data_valid),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .i_grant(i_grant), .d_grant(d_grant),
    .i_data_valid(i_data_valid), .d_data_valid(d_data_valid),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // {i_grant, d_grant, mem_en, mem_wr, i_data_valid, d_data_valid}
  typedef struct packed {
    logic [5:0]  ctl;
    logic [15:0] addr;
    logic [15:0] wdata;
  } exp_t;

  localparam logic [5:0] CTL_I = 6'b101010;
  localparam logic [5:0] CTL_D = 6'b011001;
  localparam logic [5:0] CTL_W = 6'b011100;

  exp_t       sb_q[$];
  exp_t       mon_e;
  logic [5:0] ctl_now;
  int         n_tests = 0;
  int         n_fail  = 0;

  assign ctl_now = {i_grant, d_grant, mem_en, mem_wr, i_data_valid, d_data_valid};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && (i_data_valid || d_data_valid || mem_wr)) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_event: got ctl=%b addr=%h, expected no event", ctl_now, mem_addr);
      end else begin
        mon_e = sb_q.pop_front();
        check("event_ctl", 32'(ctl_now), 32'(mon_e.ctl));
        check("event_addr", 32'(mem_addr), 32'(mon_e.addr));
        check("event_wdata", 32'(mem_wdata), 32'(mon_e.wdata));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for a grant and checks owner plus the number of negedges it took.
  task automatic wait_grant(input bit is_i, input int exp_wait, input string name);
    int waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!(i_grant || d_grant) && waited < exp_wait + 2);
    check({name, "_i_grant"}, 32'(i_grant), 32'(is_i));
    check({name, "_d_grant"}, 32'(d_grant), 32'(!is_i));
    check({name, "_latency"}, 32'(waited), 32'(exp_wait));
  endtask

  // Entered at a negedge with the grant visible; plays memory with the given latency.
  task automatic serve_fill(input bit is_i, input logic [15:0] base, input int lat,
                            input bit drop_all);
    for (int k = 0; k < lat; k++) tick();
    for (int b = 0; b < BEATS; b++) begin
      if (is_i) i_addr = base + 16'(b);
      else      d_addr = base + 16'(b);
      sb_q.push_back('{ctl: (is_i ? CTL_I : CTL_D), addr: base + 16'(b), wdata: 16'h0});
      mem_data_valid = 1'b1;
      tick();
    end
    mem_data_valid = 1'b0;
    if (drop_all) begin
      i_req = 1'b0;
      d_req = 1'b0;
    end
    @(negedge clk);
    check("fill_end_busy", 32'(busy), 0);
    check("fill_end_grant", 32'({i_grant, d_grant}), 0);
    check("fill_end_mem_en", 32'(mem_en), 0);
  endtask

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; i_req = 1'b1; d_req = 1'b1; d_wr = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0; mem_data_valid = 1'b1;

    // Reset holds everything quiet even with requests and a valid asserted.
    repeat (2) @(negedge clk);
    check("reset_ctl", 32'(ctl_now), 0);
    check("reset_addr", 32'(mem_addr), 0);
    check("reset_wdata", 32'(mem_wdata), 0);
    check("reset_busy", 32'(busy), 0);
    mem_data_valid = 1'b0;
    rst_n = 1'b1;
    wait_grant(1'b1, 1, "reset_release");
    #1 rst_n = 1'b0; i_req = 1'b0; d_req = 1'b0;
    @(negedge clk) rst_n = 1'b1;

    // Single I fill.
    tick();
    i_addr = 16'h1230; i_req = 1'b1;
    wait_grant(1'b1, 2, "ifill");
    check("ifill_addr", 32'(mem_addr), 32'h1230);
    check("ifill_mem_en", 32'(mem_en), 1);
    serve_fill(1'b1, 16'h1230, 4, 1'b1);

    // Store beats a simultaneous I fill request; stray valid during the store is dropped.
    tick();
    d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h00F0; d_wdata = 16'hBEEF;
    i_req = 1'b1; i_addr = 16'h2000;
    sb_q.push_back('{ctl: CTL_W, addr: 16'h00F0, wdata: 16'hBEEF});
    @(negedge clk);
    check("store_idle_mem_en", 32'(mem_en), 0);
    tick();
    d_req = 1'b0; d_wr = 1'b0; mem_data_valid = 1'b1;
    @(negedge clk);
    check("store_busy", 32'(busy), 1);
    tick();
    mem_data_valid = 1'b0;
    @(negedge clk);
    check("store_gap_busy", 32'(busy), 0);
    check("store_gap_i_grant", 32'(i_grant), 0);
    wait_grant(1'b1, 1, "store_then_ifill");
    serve_fill(1'b1, 16'h2000, 2, 1'b1);

    // Round robin from reset with both fill requests held.
    tick();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; i_req = 1'b1; d_req = 1'b1; d_wr = 1'b0;
    i_addr = 16'h3000; d_addr = 16'h4000;
    wait_grant(1'b1, 1, "rr0");
    serve_fill(1'b1, 16'h3000, 1, 1'b0);
    wait_grant(1'b0, 1, "rr1");
    serve_fill(1'b0, 16'h4000, 1, 1'b0);
    wait_grant(1'b1, 1, "rr2");
    serve_fill(1'b1, 16'h3100, 1, 1'b0);
    wait_grant(1'b0, 1, "rr3");
    serve_fill(1'b0, 16'h4100, 1, 1'b1);

    // Stray valid in IDLE, then a D fill that must still take its own 8 beats.
    tick();
    mem_data_valid = 1'b1;
    @(negedge clk);
    check("stray_dv", 32'({i_data_valid, d_data_valid}), 0);
    check("stray_busy", 32'(busy), 0);
    tick();
    mem_data_valid = 1'b0; d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h5000;
    wait_grant(1'b0, 2, "stray_dfill");
    serve_fill(1'b0, 16'h5000, 2, 1'b1);

    // Reset after the 3rd beat of a D fill aborts it at once; next fill counts from zero.
    tick();
    d_req = 1'b1; d_addr = 16'h6000;
    wait_grant(1'b0, 2, "abort_dfill");
    tick();
    for (int b = 0; b < 3; b++) begin
      d_addr = 16'h6000 + 16'(b);
      sb_q.push_back('{ctl: CTL_D, addr: 16'h6000 + 16'(b), wdata: 16'h0});
      mem_data_valid = 1'b1;
      tick();
    end
    mem_data_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("abort_d_grant", 32'(d_grant), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_mem_en", 32'(mem_en), 0);
    @(negedge clk);
    rst_n = 1'b1; d_addr = 16'h7000;
    wait_grant(1'b0, 1, "after_abort");
    serve_fill(1'b0, 16'h7000, 3, 1'b1);

    tick();
    check("scoreboard_empty", 32'(sb_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single-ported, pipelined main memory between the I-cache fill FSM and the D-cache (fill FSM plus write-through stores). Sits between both cache controllers and the memory model. It grants one requester at a time, muxes address, data and command onto the memory port, and steers `mem_data_valid` back to the owner. Fills are never preempted.

## Interface
- `BEATS`, 8: words returned per block fill.
- `CNT_W`, 4: beat-counter width; must hold `BEATS`.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `i_req`  in  1  I-cache fill request; held high for the whole fill.
- `i_addr`  in  16  I-cache fill FSM's current memory address.
- `d_req`  in  1  D-cache request (fill or store); held high until served.
- `d_wr`  in  1  D-cache request type, sampled with `d_req`: 1 = store, 0 = fill.
- `d_addr`  in  16  D-cache address.
- `d_wdata`  in  16  store data.
- `mem_data_valid`  in  1  memory read-data-valid strobe.
- `mem_en`  out  1  memory access enable.
- `mem_wr`  out  1  memory write enable.
- `mem_addr`  out  16  memory address.
- `mem_wdata`  out  16  memory write data.
- `i_grant`  out  1  I-cache owns memory.
- `d_grant`  out  1  D-cache owns memory.
- `i_data_valid`  out  1  `mem_data_valid` steered to I-cache.
- `d_data_valid`  out  1  `mem_data_valid` steered to D-cache.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, I_FILL, D_FILL, D_WRITE. State, beat count and `last_i` (last fill owner) are registered and cleared by reset.
- Transitions out of IDLE:
  - `d_req & d_wr` → D_WRITE. Stores have top priority.
  - Else `i_req & d_req & ~d_wr` → round-robin between fills: D_FILL if `last_i`=1, I_FILL if `last_i`=0.
  - Else `d_req & ~d_wr` → D_FILL.
  - Else `i_req` → I_FILL.
  - Else stay in IDLE.
- On entering I_FILL set `last_i`=1. On entering D_FILL set `last_i`=0. D_WRITE does not change `last_i`.
- D_WRITE lasts exactly one cycle, then returns to IDLE.
- I_FILL and D_FILL:
  - Beat counter is cleared on entry.
  - Counter increments on each `mem_data_valid`.
  - When `mem_data_valid` arrives with count = `BEATS`-1, the next state is IDLE.
  - Requester `req` is ignored until exit. Dropping `req` mid-fill is a protocol error and does not end the fill.
- Outputs, all combinational from state and inputs:
  - `i_grant` = (state==I_FILL). `d_grant` = (state==D_FILL or D_WRITE).
  - `mem_en` = `i_req` in I_FILL, `d_req` in D_FILL, 1 in D_WRITE, 0 in IDLE.
  - `mem_wr` = 1 only in D_WRITE.
  - `mem_addr` = `i_addr` in I_FILL, `d_addr` in D_FILL/D_WRITE, 0 in IDLE.
  - `mem_wdata` = `d_wdata` in D_WRITE, else 0.
  - `i_data_valid` = `mem_data_valid` & I_FILL. `d_data_valid` = `mem_data_valid` & D_FILL.
- A `mem_data_valid` in IDLE or D_WRITE is dropped: it is not steered and not counted.

## Timing
- Reset values: state IDLE, count 0, `last_i` 0. All outputs 0.
- Asserting `rst_n`=0 mid-fill forces IDLE immediately. The aborted fill is not resumed.
- Grant latency: a request seen in IDLE at edge N gives a grant and `mem_en` during cycle N+1. IDLE never issues a memory access.
- A fill occupies 1 + (cycles until the `BEATS`th valid) cycles in its state. `busy` drops the cycle after the last beat.
- Back-to-back: a request pending at the last-beat edge enters IDLE first. The new grant appears one cycle later, giving a minimum one-cycle IDLE gap.
- A store arriving during a fill waits. It wins over any fill request at the next IDLE.
- `mem_data_valid` coinciding with the exit edge is counted and steered. It belongs to the current owner.

## Test plan
- Reset: `rst_n`=0 with `i_req`=`d_req`=1 → all outputs 0. After release, `i_grant` or `d_grant` is asserted within 2 cycles.
- Single I fill: `i_req`=1, `i_addr`=0x1230. Memory returns 8 valids at latency 4 → `i_grant` high throughout, `mem_addr` tracks `i_addr`, exactly 8 `i_data_valid` pulses, `busy` low the cycle after the 8th.
- Store priority: `d_req`=1, `d_wr`=1, `d_addr`=0x00F0, `d_wdata`=0xBEEF together with `i_req`=1 → D_WRITE first, with `mem_en`=`mem_wr`=1 and address/data matching for one cycle. I_FILL follows after one IDLE cycle.
- Round robin: both fill requests held continuously → grant sequence I, D, I, D from reset, each fill exactly 8 beats long.
- Stray valid: `mem_data_valid` pulsed in IDLE, then a D fill → no `*_data_valid` pulse in IDLE, and the fill still ends after its own 8th beat.
- Mid-fill reset: assert `rst_n`=0 after the 3rd beat of a D fill → `d_grant`=0 and `busy`=0 immediately. The next D fill counts a full 8 beats.
